// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider for the RV32M div/divu/rem/remu group.
// Retires BITS_PER_CYCLE quotient bits per CALC cycle; divide-by-zero and overflow finish at once.
module div_seq #(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_enabled,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   output logic        o_busy,
   output logic        o_completed,
   output logic [31:0] o_result
);

   localparam int unsigned Iters    = 32 / BITS_PER_CYCLE;
   localparam logic [4:0]  LastIter = 5'(Iters - 1);

   if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
      $error("div_seq: BITS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e      r_state, w_state_next;
   logic        w_accept, w_calc, w_fix;
   logic        w_signed, w_div_zero, w_overflow, w_special;
   logic [31:0] w_abs1, w_abs2, w_special_result;
   logic        r_is_rem, r_neg_q, r_neg_r, r_completed;
   logic [31:0] r_dividend, r_divisor, r_quot, r_result;
   logic [32:0] r_rem;
   logic [4:0]  r_cnt;
   logic [31:0] w_dvd_step, w_quot_step, w_quot_fix, w_rem_fix, w_fix_result;
   logic [32:0] w_rem_step, w_diff;

   always_ff @(posedge i_clk) begin : p_state_reg
      if (!i_rstn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin : p_next_state
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (i_enabled) w_state_next = w_special ? StDone : StCalc;
         StCalc:  if (r_cnt == LastIter) w_state_next = StFix;
         StFix:   w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin : p_outputs
      o_busy   = (r_state != StIdle);
      w_accept = (r_state == StIdle) && i_enabled;
      w_calc   = (r_state == StCalc);
      w_fix    = (r_state == StFix);
   end

   // Request decode; op[0]=0 selects the signed variants.
   assign w_signed   = ~i_op[0];
   assign w_div_zero = (i_rs2 == 32'h0);
   assign w_overflow = w_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
   assign w_special  = w_div_zero || w_overflow;
   assign w_abs1     = (w_signed && i_rs1[31]) ? (32'h0 - i_rs1) : i_rs1;
   assign w_abs2     = (w_signed && i_rs2[31]) ? (32'h0 - i_rs2) : i_rs2;

   always_comb begin : p_special
      if (w_div_zero) begin
         w_special_result = i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
      end else begin
         w_special_result = i_op[1] ? 32'h0 : 32'h8000_0000;
      end
   end

   always_comb begin : p_step
      w_rem_step  = r_rem;
      w_quot_step = r_quot;
      w_dvd_step  = r_dividend;
      w_diff      = '0;
      for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
         w_rem_step = {w_rem_step[31:0], w_dvd_step[31]};
         w_dvd_step = {w_dvd_step[30:0], 1'b0};
         w_diff     = w_rem_step - {1'b0, r_divisor};
         if (!w_diff[32]) begin
            w_rem_step  = w_diff;
            w_quot_step = {w_quot_step[30:0], 1'b1};
         end else begin
            w_quot_step = {w_quot_step[30:0], 1'b0};
         end
      end
   end

   assign w_quot_fix   = r_neg_q ? (32'h0 - r_quot) : r_quot;
   assign w_rem_fix    = r_neg_r ? (32'h0 - r_rem[31:0]) : r_rem[31:0];
   assign w_fix_result = r_is_rem ? w_rem_fix : w_quot_fix;

   always_ff @(posedge i_clk) begin : p_datapath
      if (!i_rstn) begin
         r_is_rem    <= 1'b0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_completed <= 1'b0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_quot      <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_result    <= '0;
      end else begin
         r_completed <= (w_state_next == StDone);
         if (w_accept) begin
            r_is_rem   <= i_op[1];
            r_neg_q    <= w_signed && (i_rs1[31] ^ i_rs2[31]);
            r_neg_r    <= w_signed && i_rs1[31];
            r_dividend <= w_abs1;
            r_divisor  <= w_abs2;
            r_quot     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            if (w_special) r_result <= w_special_result;
         end else if (w_calc) begin
            r_dividend <= w_dvd_step;
            r_quot     <= w_quot_step;
            r_rem      <= w_rem_step;
            r_cnt      <= r_cnt + 5'd1;
         end else if (w_fix) begin
            r_result <= w_fix_result;
         end
      end
   end

   assign o_completed = r_completed;
   assign o_result    = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: three instances (1, 2 and 4 bits per cycle) share the stimulus and are
// checked against an arithmetic reference model, including exact latency and handshake behaviour.
module tb_div_seq;

   logic        clk = 1'b0;
   logic [2:0]  rstn;
   logic        en;
   logic [1:0]  op;
   logic [31:0] rs1, rs2;
   logic [2:0]  busy, comp;
   logic [31:0] res [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_seq #(.BITS_PER_CYCLE(1)) u_dut_b1 (
      .i_clk(clk), .i_rstn(rstn[0]), .i_enabled(en), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
      .o_busy(busy[0]), .o_completed(comp[0]), .o_result(res[0])
   );
   div_seq #(.BITS_PER_CYCLE(2)) u_dut_b2 (
      .i_clk(clk), .i_rstn(rstn[1]), .i_enabled(en), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
      .o_busy(busy[1]), .o_completed(comp[1]), .o_result(res[1])
   );
   div_seq #(.BITS_PER_CYCLE(4)) u_dut_b4 (
      .i_clk(clk), .i_rstn(rstn[2]), .i_enabled(en), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
      .o_busy(busy[2]), .o_completed(comp[2]), .o_result(res[2])
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // RV32M semantics in plain 64-bit arithmetic (truncating division, remainder takes dividend sign).
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb;
      if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return o[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return o[1] ? (a % b) : (a / b);
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic scramble();
      op  = 2'($urandom);
      rs1 = $urandom;
      rs2 = $urandom | 32'h1;
   endtask

   // mode 0: quiet; 1: enabled pulses while busy; 2: request in the shared DONE cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int mode);
      logic [31:0] exp;
      bit          special;
      bit   [2:0]  done;
      int          lat_exp [3];
      int          lat [3];
      int          pulses [3];
      int          busy_cyc [3];
      logic [31:0] res_done [3];
      exp     = model(o, a, b);
      special = (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      done    = '0;
      for (int d = 0; d < 3; d++) begin
         lat_exp[d]  = special ? 1 : (32 >> d) + 2;
         lat[d]      = 0;
         pulses[d]   = 0;
         busy_cyc[d] = 0;
         res_done[d] = 'x;
      end
      op  = o;
      rs1 = a;
      rs2 = b;
      en  = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      scramble();
      for (int c = 1; c <= 40; c++) begin
         for (int d = 0; d < 3; d++) begin
            if (busy[d] && !done[d]) busy_cyc[d]++;
            if (comp[d]) begin
               pulses[d]++;
               if (!done[d]) begin
                  done[d]     = 1'b1;
                  lat[d]      = c;
                  res_done[d] = res[d];
               end
            end
         end
         if (done == 3'b111) break;
         en = (mode == 1) && (c == 3 || c == 5 || c == 10);
         scramble();
         @(posedge clk); #1;
      end
      en = (mode == 2);
      scramble();
      @(posedge clk); #1;
      en = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("%s b%0d result", tag, 1 << d), res_done[d], exp);
         check_eq($sformatf("%s b%0d latency", tag, 1 << d), 32'(lat[d]), 32'(lat_exp[d]));
         check_eq($sformatf("%s b%0d busy_cycles", tag, 1 << d), 32'(busy_cyc[d]),
                  32'(lat_exp[d]));
         check_eq($sformatf("%s b%0d pulses", tag, 1 << d), 32'(pulses[d]), 32'd1);
         check_eq($sformatf("%s b%0d idle_busy", tag, 1 << d), 32'(busy[d]), 32'd0);
         check_eq($sformatf("%s b%0d idle_comp", tag, 1 << d), 32'(comp[d]), 32'd0);
         check_eq($sformatf("%s b%0d held", tag, 1 << d), res[d], exp);
      end
   endtask

   task automatic reset_mid();
      int pulses [3];
      op  = 2'b01;
      rs1 = 32'hFFFF_FFFF;
      rs2 = 32'd3;
      en  = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         @(posedge clk); #1;
         if (c == 5) rstn[2] = 1'b0;
         if (c == 6) begin
            check_eq("rst b4 busy", 32'(busy[2]), 32'd0);
            check_eq("rst b4 comp", 32'(comp[2]), 32'd0);
            check_eq("rst b4 result", res[2], 32'd0);
            rstn[2] = 1'b1;
         end
         if (c == 10) rstn[1:0] = 2'b00;
         if (c == 11) begin
            for (int d = 0; d < 2; d++) begin
               check_eq($sformatf("rst b%0d busy", 1 << d), 32'(busy[d]), 32'd0);
               check_eq($sformatf("rst b%0d comp", 1 << d), 32'(comp[d]), 32'd0);
               check_eq($sformatf("rst b%0d result", 1 << d), res[d], 32'd0);
            end
            rstn[1:0] = 2'b11;
         end
      end
      for (int d = 0; d < 3; d++) pulses[d] = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) if (comp[d]) pulses[d]++;
      end
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("rst b%0d late_comp", 1 << d), 32'(pulses[d]), 32'd0);
      end
   endtask

   initial begin
      rstn = 3'b000;
      en   = 1'b0;
      op   = 2'b00;
      rs1  = 32'h0;
      rs2  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check_eq($sformatf("por b%0d busy", 1 << d), 32'(busy[d]), 32'd0);
         check_eq($sformatf("por b%0d comp", 1 << d), 32'(comp[d]), 32'd0);
         check_eq($sformatf("por b%0d result", 1 << d), res[d], 32'd0);
      end
      rstn = 3'b111;
      @(posedge clk); #1;

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
      run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("remu_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
      run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 0);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);
      run_op("div_5_0", 2'b00, 32'd5, 32'd0, 0);
      run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 0);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("busy_pulses", 2'b01, 32'd1000, 32'd10, 1);
      run_op("done_request", 2'b00, 32'd5, 32'd0, 2);
      run_op("pre_reset", 2'b01, 32'd100, 32'd7, 0);
      reset_mid();
      run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 0);

      for (int n = 0; n < 1200; n++) begin
         run_op($sformatf("rnd%0d", n), 2'($urandom), pick(), pick(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
